// File: rtl/spatz_div_arbiter.sv
// spatz_div_arbiter
// Lets NumReq SIMD lanes share one serial divider, with one operation in
// flight at a time. In IDLE a round-robin scan picks one requesting lane.
// A legal op is sent to the divider (ISSUE), the arbiter waits for the
// divider result (WAIT), and the result goes back to the granted lane (RESP).
// An illegal op skips the divider, returns zero and sets the sticky error.
module spatz_div_arbiter #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned Width   = 32,
  parameter int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0][3:0]        req_op_i,
  input  logic [NumReq-1:0][Width-1:0]  req_op_a_i,
  input  logic [NumReq-1:0][Width-1:0]  req_op_b_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [Width-1:0]              rsp_result_o,
  output logic                          div_in_valid_o,
  input  logic                          div_in_ready_i,
  output logic [31:0]                   div_op_o,
  output logic [Width-1:0]              div_op_a_o,
  output logic [Width-1:0]              div_op_b_o,
  output logic [IdWidth-1:0]            div_id_o,
  input  logic                          div_out_valid_i,
  output logic                          div_out_ready_o,
  input  logic [IdWidth-1:0]            div_id_i,
  input  logic [Width-1:0]              div_result_i,
  output logic                          err_o,
  output logic [15:0]                   done_cnt_o
);

  // Lane operation encoding. The divide family uses the RISC-V funct3 value
  // of the matching divider opcode, so the opcode can be rebuilt directly.
  localparam logic [3:0] OpVAdd  = 4'd0;
  localparam logic [3:0] OpVMul  = 4'd1;
  localparam logic [3:0] OpVDiv  = 4'd4;
  localparam logic [3:0] OpVDivu = 4'd5;
  localparam logic [3:0] OpVRem  = 4'd6;
  localparam logic [3:0] OpVRemu = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e             state_q;
  logic [IdWidth-1:0] rr_q;
  logic [IdWidth-1:0] grant_q;
  logic [3:0]         op_q;
  logic [Width-1:0]   opA_q;
  logic [Width-1:0]   opB_q;
  logic [Width-1:0]   result_q;
  logic               err_q;
  logic [15:0]        doneCnt_q;

  logic               anyValid;
  logic [IdWidth-1:0] grantIdx;
  logic [IdWidth-1:0] cand;
  logic [IdWidth-1:0] rr_d;

  function automatic logic isDivOp(input logic [3:0] op);
    case (op)
      OpVDiv, OpVDivu, OpVRem, OpVRemu: isDivOp = 1'b1;
      OpVAdd, OpVMul:                   isDivOp = 1'b0;
      default:                          isDivOp = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] divOpcode(input logic [3:0] op);
    case (op)
      OpVDiv:  divOpcode = 32'h0200_4033;
      OpVDivu: divOpcode = 32'h0200_5033;
      OpVRem:  divOpcode = 32'h0200_6033;
      OpVRemu: divOpcode = 32'h0200_7033;
      default: divOpcode = 32'h0000_0000;
    endcase
  endfunction

  // Round-robin scan: the first valid lane at or after rr_q, wrapping modulo NumReq.
  always_comb begin
    anyValid = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdWidth'((32'(rr_q) + i) % NumReq);
      if (!anyValid && req_valid_i[cand]) begin
        anyValid = 1'b1;
        grantIdx = cand;
      end
    end
    rr_d = IdWidth'((32'(grantIdx) + 32'd1) % NumReq);
  end

  // Control FSM: grant in IDLE, hand off to the divider, collect the result, return it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      op_q      <= OpVAdd;
      opA_q     <= '0;
      opB_q     <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      doneCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyValid) begin
            grant_q <= grantIdx;
            rr_q    <= rr_d;
            op_q    <= req_op_i[grantIdx];
            opA_q   <= req_op_a_i[grantIdx];
            opB_q   <= req_op_b_i[grantIdx];
            if (isDivOp(req_op_i[grantIdx])) begin
              state_q <= ISSUE;
            end else begin
              result_q <= '0;
              err_q    <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        ISSUE: begin
          if (div_in_ready_i) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (div_out_valid_i) begin
            result_q <= div_result_i;
            if (div_id_i != grant_q) begin
              err_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i[grant_q]) begin
            if (doneCnt_q != 16'hFFFF) begin
              doneCnt_q <= doneCnt_q + 16'd1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from the registered state. The reset gate
  // on the grant keeps req_ready_o low while reset is held, even when lanes
  // are already requesting.
  always_comb begin
    req_ready_o     = '0;
    if (state_q == IDLE && anyValid && rst_ni) begin
      req_ready_o = NumReq'(1) << grantIdx;
    end
    rsp_valid_o     = (state_q == RESP) ? (NumReq'(1) << grant_q) : '0;
    div_in_valid_o  = (state_q == ISSUE);
    div_out_ready_o = (state_q == WAIT);
  end

  assign rsp_result_o = result_q;
  assign div_op_o     = divOpcode(op_q);
  assign div_op_a_o   = opA_q;
  assign div_op_b_o   = opB_q;
  assign div_id_o     = grant_q;
  assign err_o        = err_q;
  assign done_cnt_o   = doneCnt_q;

endmodule
